pc_next_ctrl: RTL and testbench

Next-PC generator for the 16-bit pipelined MIPS fetch stage: the producer side of the `PC_in`/`PC_out` interface of the `PC` register. Each cycle it selects the next fetch address (sequential, jump from ID, taken branch from EX, or hold on stall) and drives it onto `PC_in`. It also tracks wrong-path fetches through a small state machine that drives pipeline flush and fetch-valid signals, and it keeps saturating stall and redirect counters.

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_next_ctrl_if.sv | 50 +++++
 rtl/pc_next_ctrl_sat_counter.sv | 20 ++
 rtl/pc_next_ctrl.sv | 86 ++++++++
 tb/tb_pc_next_ctrl.sv | 128 ++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the next-PC controller slice.
// Word-addressed 16-bit PC, boot vector and fetch FSM states.
package pc_pkg;

  localparam int ADDR_W = 16;
  localparam int CNT_W  = 16;

  localparam logic [ADDR_W-1:0] RESET_VEC = 16'h0000;
  localparam logic [ADDR_W-1:0] PC_STEP   = 16'h0001;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    STALL,
    FLUSH
  } state_t;

endpackage

// File: rtl/pc_next_ctrl_if.sv
// Fetch-control bundle between next-PC logic and the PC register.
// master = next-PC generator, slave = PC register / pipeline side.
import pc_pkg::*;

interface pc_next_ctrl_if;

  logic [ADDR_W-1:0] PC_out;
  logic              stall;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] PC_in;
  logic              flush_ifid;
  logic              flush_idex;
  logic              fetch_valid;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  redirect_cnt;

  modport master (
    input  PC_out,
    input  stall,
    input  jump,
    input  jump_target,
    input  branch_taken,
    input  branch_target,
    output PC_in,
    output flush_ifid,
    output flush_idex,
    output fetch_valid,
    output stall_cnt,
    output redirect_cnt
  );

  modport slave (
    output PC_out,
    output stall,
    output jump,
    output jump_target,
    output branch_taken,
    output branch_target,
    input  PC_in,
    input  flush_ifid,
    input  flush_idex,
    input  fetch_valid,
    input  stall_cnt,
    input  redirect_cnt
  );

endinterface

// File: rtl/pc_next_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pc_next_ctrl.sv
// Next-PC select, redirect flushes and wrong-path fetch tracking.
// PC_in and flushes are combinational; fetch_valid is registered.
import pc_pkg::*;

module pc_next_ctrl (
    input logic                  clk,
    input logic                  rst,
    pc_next_ctrl_if.master       bus
);

  state_t state;
  logic   eff_jump;
  logic   redirect;
  logic   stall_inc;

  // A jump under stall is dropped; ID re-presents it later.
  always_comb begin
    eff_jump  = bus.jump & ~bus.stall & ~bus.branch_taken;
    redirect  = bus.branch_taken | eff_jump;
    stall_inc = bus.stall & ~bus.branch_taken;
  end

  always_comb begin
    bus.PC_in      = bus.PC_out + PC_STEP;
    bus.flush_ifid = 1'b0;
    bus.flush_idex = 1'b0;
    if (rst) begin
      bus.PC_in = RESET_VEC;
    end else if (bus.branch_taken) begin
      bus.PC_in      = bus.branch_target;
      bus.flush_ifid = 1'b1;
      bus.flush_idex = 1'b1;
    end else if (eff_jump) begin
      bus.PC_in      = bus.jump_target;
      bus.flush_ifid = 1'b1;
    end else if (bus.stall) begin
      bus.PC_in = bus.PC_out;
    end
  end

  // Sync imem returns the wrong-path word the cycle after a redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= BOOT;
      bus.fetch_valid <= 1'b0;
    end else begin
      unique case (state)
        BOOT: begin
          state           <= RUN;
          bus.fetch_valid <= 1'b1;
        end
        RUN, STALL, FLUSH: begin
          if (redirect) begin
            state           <= FLUSH;
            bus.fetch_valid <= 1'b0;
          end else if (bus.stall) begin
            state           <= STALL;
            bus.fetch_valid <= 1'b1;
          end else begin
            state           <= RUN;
            bus.fetch_valid <= 1'b1;
          end
        end
        default: begin
          state           <= BOOT;
          bus.fetch_valid <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirect),
    .count (bus.redirect_cnt)
  );

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Scoreboard bench for pc_next_ctrl: driver queues hand-computed
// expectations, a negedge monitor pops and compares each cycle.
module tb_pc_next_ctrl;

  typedef struct {
    string       tag;
    logic [15:0] pc_in;
    logic        fi;
    logic        fx;
    logic        fv;
    logic [15:0] sc;
    logic [15:0] rc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  pc_next_ctrl_if bus ();

  pc_next_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk16(string tag, string f, logic [15:0] act, logic [15:0] req);
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s got %h want %h", tag, f, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      chk16(e.tag, "PC_in", bus.PC_in, e.pc_in);
      chk16(e.tag, "flush_ifid", {15'd0, bus.flush_ifid}, {15'd0, e.fi});
      chk16(e.tag, "flush_idex", {15'd0, bus.flush_idex}, {15'd0, e.fx});
      chk16(e.tag, "fetch_valid", {15'd0, bus.fetch_valid}, {15'd0, e.fv});
      chk16(e.tag, "stall_cnt", bus.stall_cnt, e.sc);
      chk16(e.tag, "redirect_cnt", bus.redirect_cnt, e.rc);
    end
  end

  task automatic step(
    input string       tag,
    input logic        r,
    input logic [15:0] pco,
    input logic        st,
    input logic        j,
    input logic [15:0] jt,
    input logic        b,
    input logic [15:0] bt,
    input logic [15:0] e_pc,
    input logic        e_fi,
    input logic        e_fx,
    input logic        e_fv,
    input logic [15:0] e_sc,
    input logic [15:0] e_rc
  );
    exp_t e;
    rst               = r;
    bus.PC_out        = pco;
    bus.stall         = st;
    bus.jump          = j;
    bus.jump_target   = jt;
    bus.branch_taken  = b;
    bus.branch_target = bt;
    e.tag   = tag;
    e.pc_in = e_pc;
    e.fi    = e_fi;
    e.fx    = e_fx;
    e.fv    = e_fv;
    e.sc    = e_sc;
    e.rc    = e_rc;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.PC_out        = 16'h0;
    bus.stall         = 1'b0;
    bus.jump          = 1'b0;
    bus.jump_target   = 16'h0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 16'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    //   tag       rst pc_out   st j jt       b bt       PC_in    fi fx fv sc rc
    step("rst",    1, 16'h0000, 0,0,16'h0000,0,16'h0000, 16'h0000,0,0,0,0,0);
    step("seq1",   0, 16'h0000, 0,0,16'h0000,0,16'h0000, 16'h0001,0,0,0,0,0);
    step("seq2",   0, 16'h0001, 0,0,16'h0000,0,16'h0000, 16'h0002,0,0,1,0,0);
    step("seq3",   0, 16'h0002, 0,0,16'h0000,0,16'h0000, 16'h0003,0,0,1,0,0);
    step("seq4",   0, 16'h0003, 0,0,16'h0000,0,16'h0000, 16'h0004,0,0,1,0,0);
    step("wrap",   0, 16'hFFFF, 0,0,16'h0000,0,16'h0000, 16'h0000,0,0,1,0,0);
    step("stl1",   0, 16'h0010, 1,0,16'h0000,0,16'h0000, 16'h0010,0,0,1,0,0);
    step("stl2",   0, 16'h0010, 1,0,16'h0000,0,16'h0000, 16'h0010,0,0,1,1,0);
    step("stl3",   0, 16'h0010, 1,0,16'h0000,0,16'h0000, 16'h0010,0,0,1,2,0);
    step("unstl",  0, 16'h0010, 0,0,16'h0000,0,16'h0000, 16'h0011,0,0,1,3,0);
    step("br_jmp", 0, 16'h0011, 0,1,16'h0080,1,16'h0040, 16'h0040,1,1,1,3,0);
    step("post_br",0, 16'h0040, 0,0,16'h0000,0,16'h0000, 16'h0041,0,0,0,3,1);
    step("run",    0, 16'h0041, 0,0,16'h0000,0,16'h0000, 16'h0042,0,0,1,3,1);
    step("jmp_stl",0, 16'h0042, 1,1,16'h0100,0,16'h0000, 16'h0042,0,0,1,3,1);
    step("jmp",    0, 16'h0042, 0,1,16'h0100,0,16'h0000, 16'h0100,1,0,1,4,1);
    step("br_stl", 0, 16'h0100, 1,0,16'h0000,1,16'h0200, 16'h0200,1,1,0,4,2);
    step("br_b2b", 0, 16'h0200, 0,0,16'h0000,1,16'h0300, 16'h0300,1,1,0,4,3);
    step("rst_fl", 1, 16'h0300, 0,1,16'h0500,0,16'h0000, 16'h0000,0,0,0,4,4);
    step("boot",   0, 16'h0000, 0,0,16'h0000,0,16'h0000, 16'h0001,0,0,0,0,0);
    step("run2",   0, 16'h0001, 0,0,16'h0000,0,16'h0000, 16'h0002,0,0,1,0,0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
